// File: rtl/cobra1_kb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cobra1_kb_pkg
// Purpose  : Cobra1 key indices, PS/2 scancode maps and receiver state type.
// Revision : 1.0
// ============================================================================
package cobra1_kb_pkg;

  localparam int KEY_IDX_W = 6;
  localparam int KEY_COUNT = 40;

  localparam logic [KEY_IDX_W-1:0] KEY_NONE  = 6'd63;
  localparam logic [KEY_IDX_W-1:0] KEY_A     = 6'd10;
  localparam logic [KEY_IDX_W-1:0] KEY_SPACE = 6'd38;
  localparam logic [KEY_IDX_W-1:0] KEY_ENTER = 6'd39;

  localparam logic [KEY_IDX_W-1:0] BASE_MAP [256] = '{
    8'h1C   : KEY_A,
    8'h29   : KEY_SPACE,
    8'h5A   : KEY_ENTER,
    default : KEY_NONE
  };

  localparam logic [KEY_IDX_W-1:0] EXT_MAP [256] = '{
    8'h5A   : KEY_ENTER,
    default : KEY_NONE
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 line conditioning, 11-bit frame deserialiser and watchdog.
// Revision : 1.0
// ============================================================================
import cobra1_kb_pkg::*;

module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 3250,
  parameter int FILTER_LEN     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            r_clk_sync, r_dat_sync;
  logic [FILTER_LEN-1:0] r_clk_hist, r_dat_hist;
  logic [FILTER_LEN-1:0] w_clk_hist_nxt, w_dat_hist_nxt;
  logic                  r_filt_clk, r_filt_dat, r_strobe;

  ps2_state_t       r_state, w_state_nxt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [TMR_W-1:0] r_timer;
  logic             w_timeout, w_byte_ok, w_err;
  logic             r_byte_vld, r_frame_err;

  // Filter decisions use the history including the newest sample, so the
  // strobe lands 2 + FILTER_LEN clocks after the raw line falls.
  assign w_clk_hist_nxt = FILTER_LEN'({r_clk_hist, r_clk_sync[1]});
  assign w_dat_hist_nxt = FILTER_LEN'({r_dat_hist, r_dat_sync[1]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_hist <= '1;
      r_dat_hist <= '1;
      r_filt_clk <= 1'b1;
      r_filt_dat <= 1'b1;
      r_strobe   <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
      r_clk_hist <= w_clk_hist_nxt;
      r_dat_hist <= w_dat_hist_nxt;
      r_strobe   <= r_filt_clk & ~(|w_clk_hist_nxt);
      if (&w_clk_hist_nxt)         r_filt_clk <= 1'b1;
      else if (~(|w_clk_hist_nxt)) r_filt_clk <= 1'b0;
      if (&w_dat_hist_nxt)         r_filt_dat <= 1'b1;
      else if (~(|w_dat_hist_nxt)) r_filt_dat <= 1'b0;
    end
  end

  assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_strobe && !r_filt_dat)             w_state_nxt = DATA;
      DATA:    if (r_strobe && r_bit_cnt == 3'd7)       w_state_nxt = PARITY;
      PARITY:  if (r_strobe)                            w_state_nxt = STOP;
      STOP:    if (r_strobe)                            w_state_nxt = IDLE;
      default:                                          w_state_nxt = IDLE;
    endcase
    if (r_state != IDLE && !r_strobe && w_timeout) w_state_nxt = IDLE;
  end

  always_comb begin
    w_byte_ok = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      IDLE: w_err = r_strobe & r_filt_dat;
      STOP: if (r_strobe) begin
        if (r_filt_dat && ((^r_shift) ^ r_parity)) w_byte_ok = 1'b1;
        else                                       w_err     = 1'b1;
      end
      default: ;
    endcase
    if (r_state != IDLE && !r_strobe && w_timeout) w_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_timer     <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= w_byte_ok;
      r_frame_err <= w_err;
      if (r_state == IDLE || r_strobe) r_timer <= '0;
      else                             r_timer <= r_timer + 1'b1;
      if (r_strobe) begin
        case (r_state)
          IDLE:   r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {r_filt_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY: r_parity <= r_filt_dat;
          default: ;
        endcase
      end
    end
  end

  assign byte_vld  = r_byte_vld;
  assign byte_data = r_shift;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_kb_matrix.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kb_matrix
// Purpose  : PS/2 keyboard to Cobra1 40-bit static key-state vector.
// Revision : 1.0
// ============================================================================
import cobra1_kb_pkg::*;

module ps2_kb_matrix #(
  parameter int TIMEOUT_CYCLES = 3250,
  parameter int FILTER_LEN     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_dat,
  output logic [KEY_COUNT-1:0] kb_state,
  output logic                 key_evt,
  output logic                 frame_err
);

  logic                 w_byte_vld, w_rx_err;
  logic [7:0]           w_byte;
  logic [KEY_IDX_W-1:0] w_idx;
  logic [KEY_COUNT-1:0] w_mask, w_key_nxt;
  logic [KEY_COUNT-1:0] r_kb_state;
  logic                 r_ext, r_brk, r_key_evt;
  logic [2:0]           r_skip;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_vld  (w_byte_vld),
    .byte_data (w_byte),
    .frame_err (w_rx_err)
  );

  always_comb begin
    w_idx  = r_ext ? EXT_MAP[w_byte] : BASE_MAP[w_byte];
    w_mask = '0;
    if (w_idx < KEY_IDX_W'(KEY_COUNT)) w_mask = KEY_COUNT'(1) << w_idx;
    w_key_nxt = r_brk ? (r_kb_state & ~w_mask) : (r_kb_state | w_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kb_state <= '0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_skip     <= '0;
      r_key_evt  <= 1'b0;
    end else begin
      r_key_evt <= 1'b0;
      if (w_rx_err) begin
        // A broken frame may have carried a prefix; never apply a stale one.
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
        r_skip <= '0;
      end else if (w_byte_vld) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 1'b1;
        end else begin
          case (w_byte)
            8'hE1: r_skip <= 3'd7;
            8'hE0: r_ext  <= 1'b1;
            8'hF0: r_brk  <= 1'b1;
            8'h00, 8'hFF: begin
              r_kb_state <= '0;
              r_key_evt  <= |r_kb_state;
              r_ext      <= 1'b0;
              r_brk      <= 1'b0;
            end
            8'hAA: begin
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
            default: begin
              r_kb_state <= w_key_nxt;
              r_key_evt  <= (w_key_nxt != r_kb_state);
              r_ext      <= 1'b0;
              r_brk      <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign kb_state  = r_kb_state;
  assign key_evt   = r_key_evt;
  assign frame_err = w_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_matrix.sv
`default_nettype none
// Directed bench for ps2_kb_matrix: drives PS/2 frames, checks key state,
// event and error pulse counts against hand-computed values.
module tb_ps2_kb_matrix;

  localparam int HALF = 20;   // PS/2 clock half period in system clocks
  localparam int GAP  = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [39:0] kb_state;
  logic        key_evt;
  logic        frame_err;

  int chk_cnt = 0;
  int err_cnt = 0;
  int evt_cnt = 0;
  int ferr_cnt = 0;

  ps2_kb_matrix #(
    .TIMEOUT_CYCLES (200),
    .FILTER_LEN     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .kb_state  (kb_state),
    .key_evt   (key_evt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_evt)   evt_cnt  = evt_cnt + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a frame: start, 8 data LSB-first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  localparam logic [39:0] B10 = 40'h1 << 10;
  localparam logic [39:0] B38 = 40'h1 << 38;
  localparam logic [39:0] B39 = 40'h1 << 39;

  initial begin
    repeat (5) @(negedge clk);
    check("reset_kb_state", kb_state, 40'h0);
    check("reset_key_evt", {39'h0, key_evt}, 40'h0);
    check("reset_frame_err", {39'h0, frame_err}, 40'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    evt_cnt = 0; ferr_cnt = 0;

    send(8'h1C);
    check("make_a", kb_state, B10);
    send(8'hF0); send(8'h1C);
    check("break_a", kb_state, 40'h0);
    check("make_break_evts", 40'(evt_cnt), 40'd2);
    check("make_break_errs", 40'(ferr_cnt), 40'd0);

    evt_cnt = 0;
    send(8'h29);
    check("make_space", kb_state, B38);
    send(8'h29); send(8'h29);
    check("repeat_state", kb_state, B38);
    check("repeat_evts", 40'(evt_cnt), 40'd1);
    send(8'hF0); send(8'h29);
    check("break_space", kb_state, 40'h0);

    send(8'hE0); send(8'h5A);
    check("ext_enter_make", kb_state, B39);
    send(8'h1C);
    check("no_stale_ext_a", kb_state, B39 | B10);
    send(8'h29);
    check("no_stale_ext_sp", kb_state, B39 | B10 | B38);
    send(8'h5A);
    check("base_enter_held", kb_state, B39 | B10 | B38);
    send(8'hE0); send(8'hF0); send(8'h5A);
    check("ext_enter_break", kb_state, B10 | B38);

    evt_cnt = 0;
    send(8'hFF);
    check("overrun_clear", kb_state, 40'h0);
    check("overrun_evts", 40'(evt_cnt), 40'd1);

    ferr_cnt = 0; evt_cnt = 0;
    send_frame(8'h1C, 1'b1, 11);
    check("bad_parity_err", 40'(ferr_cnt), 40'd1);
    check("bad_parity_state", kb_state, 40'h0);

    ferr_cnt = 0;
    send(8'hF0);
    send_frame(8'h00, 1'b0, 5);
    repeat (250) @(negedge clk);
    check("timeout_err", 40'(ferr_cnt), 40'd1);
    send(8'h1C);
    check("after_timeout_make", kb_state, B10);

    evt_cnt = 0; ferr_cnt = 0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_state", kb_state, B10);
    check("pause_evts", 40'(evt_cnt), 40'd0);
    send(8'h29);
    check("after_pause_make", kb_state, B10 | B38);

    ferr_cnt = 0;
    for (int g = 0; g < 8; g++) begin
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
      repeat (9) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("glitch_no_strobe", 40'(ferr_cnt), 40'd0);
    check("glitch_state", kb_state, B10 | B38);

    send_frame(8'h5A, 1'b0, 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_reset_state", kb_state, 40'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    evt_cnt = 0; ferr_cnt = 0;
    send(8'h1C);
    check("post_reset_make", kb_state, B10);
    check("post_reset_evts", 40'(evt_cnt), 40'd1);
    check("post_reset_errs", 40'(ferr_cnt), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
